// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED demux scan sequencer.
package led_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_SCAN   = 2'b10,
    ST_PAUSE  = 2'b11
  } state_t;

  localparam int   NUM_OUT = 4;
  localparam int   SEL_W   = 2;
  localparam logic DIR_UP  = 1'b0;
  localparam logic DIR_DN  = 1'b1;

  // Select after one scan step; the 2-bit result wraps modulo NUM_OUT.
  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel,
                                                input logic             dir);
    return (dir == DIR_DN) ? sel - SEL_W'(1) : sel + SEL_W'(1);
  endfunction

  function automatic logic step_wraps(input logic [SEL_W-1:0] sel,
                                      input logic             dir);
    return (dir == DIR_DN) ? (sel == '0) : (sel == SEL_W'(NUM_OUT - 1));
  endfunction

endpackage

// File: rtl/led_scan_ctrl_tick.sv
// Scan prescaler: counts 0..PRESCALE-1 while running; o_tick flags the terminal count.
module scan_tick_gen
  import led_scan_pkg::*;
#(
  parameter int PRESCALE = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_scan_ctrl.sv
// LED demux sequencer: manual pass-through or prescaled auto scan with pause/resume.
// Optional macro LED_SCAN_BLINK_EN: the selected LED blinks while paused.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int PRESCALE = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sw,
  input  logic             mode_auto,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             dir,
  output logic [SEL_W-1:0] demux_ctrl,
  output logic             demux_en,
  output logic             wrap,
  output logic [1:0]       state_o
);

  state_t           r_state, w_state_d;
  logic [SEL_W-1:0] r_ctrl, w_ctrl_d;
  logic             r_en, w_en_d;
  logic             r_wrap, w_wrap_d;
  logic             w_run, w_clr, w_tick;

  scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (w_run),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
      r_en    <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ctrl  <= w_ctrl_d;
      r_en    <= w_en_d;
      r_wrap  <= w_wrap_d;
    end
  end

  // Command priority is stop > pause > start in every state.
  always_comb begin
    w_state_d = r_state;
    w_ctrl_d  = r_ctrl;
    w_en_d    = r_en;
    w_wrap_d  = 1'b0;
    w_run     = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_en_d = 1'b0;
        if (!stop && !pause && start) begin
          w_en_d = 1'b1;
          if (mode_auto) begin
            w_state_d = ST_SCAN;
            w_ctrl_d  = (dir == DIR_DN) ? SEL_W'(NUM_OUT - 1) : '0;
            w_clr     = 1'b1;
          end else begin
            w_state_d = ST_MANUAL;
          end
        end
      end
      ST_MANUAL: begin
        if (stop) begin
          w_state_d = ST_IDLE;
          w_en_d    = 1'b0;
        end else begin
          w_ctrl_d = sw;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          w_state_d = ST_IDLE;
          w_en_d    = 1'b0;
          w_clr     = 1'b1;
        end else if (pause) begin
          // Pausing on the step cycle swallows the step and restarts the period.
          w_state_d = ST_PAUSE;
          w_clr     = w_tick;
        end else begin
          w_run = 1'b1;
          if (w_tick) begin
            w_ctrl_d = step_sel(r_ctrl, dir);
            w_wrap_d = step_wraps(r_ctrl, dir);
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_state_d = ST_IDLE;
          w_en_d    = 1'b0;
          w_clr     = 1'b1;
        end else if (!pause && start) begin
          w_state_d = ST_SCAN;
`ifdef LED_SCAN_BLINK_EN
          w_clr  = 1'b1;
          w_en_d = 1'b1;
`endif
        end else begin
`ifdef LED_SCAN_BLINK_EN
          w_run = 1'b1;
          if (w_tick) w_en_d = ~r_en;
`endif
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  assign demux_ctrl = r_ctrl;
  assign demux_en   = r_en;
  assign wrap       = r_wrap;
  assign state_o    = r_state;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (PRESCALE=4): directed scenarios plus random commands.
module tb_led_scan_ctrl;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw = '0;
  logic       mode_auto = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0, dir = 1'b0;
  logic [1:0] demux_ctrl;
  logic       demux_en, wrap;
  logic [1:0] state_o;

  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;

  // Behavioural model: 0=idle 1=manual 2=scan 3=pause; m_cnt = cycles into the current step period.
  int m_st, m_sel, m_cnt, m_en, m_wrap;

  led_scan_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .mode_auto  (mode_auto),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .dir        (dir),
    .demux_ctrl (demux_ctrl),
    .demux_en   (demux_en),
    .wrap       (wrap),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sel = 0; m_cnt = 0; m_en = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int d, nxt;
    m_wrap = 0;
    d = dir ? -1 : 1;
    case (m_st)
      0: if (!stop && !pause && start) begin
           m_en = 1;
           if (mode_auto) begin
             m_st = 2; m_sel = dir ? 3 : 0; m_cnt = 0;
           end else begin
             m_st = 1;
           end
         end
      1: if (stop) begin m_st = 0; m_en = 0; end
         else m_sel = int'(sw);
      2: if (stop) begin m_st = 0; m_en = 0; end
         else if (pause) begin
           m_st = 3;
           if (m_cnt == PRESCALE - 1) m_cnt = 0;
         end else if (m_cnt == PRESCALE - 1) begin
           m_cnt = 0;
           nxt = (m_sel + d + 4) % 4;
           m_wrap = ((m_sel + d) != nxt) ? 1 : 0;
           m_sel = nxt;
         end else begin
           m_cnt++;
         end
      default: if (stop) begin m_st = 0; m_en = 0; end
               else if (!pause && start) m_st = 2;
    endcase
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_ctrl"}, 32'(demux_ctrl), 0);
    chk({tag, "_en"}, 32'(demux_en), 0);
    chk({tag, "_wrap"}, 32'(wrap), 0);
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      if (!done) begin
        chk("cyc_state", 32'(state_o), 32'(m_st));
        chk("cyc_ctrl", 32'(demux_ctrl), 32'(m_sel));
        chk("cyc_en", 32'(demux_en), 32'(m_en));
        chk("cyc_wrap", 32'(wrap), 32'(m_wrap));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("rst0");

    // Manual pass-through
    mode_auto = 1'b0; start = 1'b1; sw = 2'd2;
    @(negedge clk); start = 1'b0;
    chk("man_state", 32'(state_o), 1);
    chk("man_en", 32'(demux_en), 1);
    @(negedge clk);
    chk("man_ctrl", 32'(demux_ctrl), 2);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("man_stop_en", 32'(demux_en), 0);
    chk("man_stop_ctrl", 32'(demux_ctrl), 2);
    chk("man_stop_state", 32'(state_o), 0);

    // Auto scan upward
    mode_auto = 1'b1; dir = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("up_entry_ctrl", 32'(demux_ctrl), 0);
    chk("up_entry_state", 32'(state_o), 2);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("up_ctrl", 32'(demux_ctrl), 32'((i / 4) % 4));
      chk("up_wrap", 32'(wrap), (i == 16) ? 1 : 0);
    end

    // Direction change mid-scan
    repeat (8) @(negedge clk);
    chk("dir_pre_ctrl", 32'(demux_ctrl), 2);
    dir = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("dn_ctrl", 32'(demux_ctrl), 32'((2 - i / 4 + 4) % 4));
      chk("dn_wrap", 32'(wrap), (i == 12) ? 1 : 0);
    end

    // Pause two cycles after a step, hold, resume
    repeat (2) @(negedge clk);
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    chk("pause_state", 32'(state_o), 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause_hold_ctrl", 32'(demux_ctrl), 3);
      chk("pause_hold_state", 32'(state_o), 3);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("resume_state", 32'(state_o), 2);
    @(negedge clk);
    chk("resume_ctrl1", 32'(demux_ctrl), 3);
    @(negedge clk);
    chk("resume_ctrl2", 32'(demux_ctrl), 2);

    // Pause landing on the step cycle
    repeat (3) @(negedge clk);
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    chk("coll_pause_state", 32'(state_o), 3);
    chk("coll_pause_ctrl", 32'(demux_ctrl), 2);
    chk("coll_pause_wrap", 32'(wrap), 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("coll_resume_state", 32'(state_o), 2);
    repeat (3) @(negedge clk);
    chk("coll_resume_hold", 32'(demux_ctrl), 2);
    @(negedge clk);
    chk("coll_resume_step", 32'(demux_ctrl), 1);

    // Stop and start together
    stop = 1'b1; start = 1'b1;
    @(negedge clk); stop = 1'b0; start = 1'b0;
    chk("coll_stop_state", 32'(state_o), 0);
    chk("coll_stop_en", 32'(demux_en), 0);
    chk("coll_stop_ctrl", 32'(demux_ctrl), 1);

    // Asynchronous reset mid-scan
    mode_auto = 1'b1; dir = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("rst_scan_state", 32'(state_o), 2);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_vals("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random command traffic
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_vals("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      start     = ($urandom_range(0, 5) == 0);
      pause     = ($urandom_range(0, 11) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      mode_auto = 1'($urandom_range(0, 1));
      sw        = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) dir = ~dir;
    end

    @(negedge clk);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
